// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide unit; the decoder drives `op` with these.
package muldiv_pkg;

    localparam logic [2:0] OP_MULTU = 3'b000;
    localparam logic [2:0] OP_DIVU  = 3'b001;
    localparam logic [2:0] OP_MTHI  = 3'b010;
    localparam logic [2:0] OP_MTLO  = 3'b011;
    localparam logic [2:0] OP_MULT  = 3'b100;
    localparam logic [2:0] OP_DIV   = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// One combinational iteration: shift-add step for multiply (LSB first),
// restoring shift-subtract step for divide (MSB first).
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] part,
    input  logic             shift_in,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] part_nxt,
    output logic             q_bit
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    always_comb begin
        sum      = {1'b0, part} + (shift_in ? {1'b0, opnd} : (WIDTH+1)'(0));
        shifted  = {part, shift_in};
        // when the subtraction is taken its true result is below 2^WIDTH, so modular width suffices
        diff     = shifted[WIDTH-1:0] - opnd;
        if (is_div) begin
            q_bit    = shifted >= {1'b0, opnd};
            part_nxt = q_bit ? diff : shifted[WIDTH-1:0];
        end else begin
            q_bit    = sum[0];
            part_nxt = sum[WIDTH:1];
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULTU/DIVU unit owning HI/LO. Signed MULT/DIV are built only when
// MULDIV_SIGNED_EN is defined.
//   state  | meaning
//   S_IDLE | waiting for start
//   S_RUN  | one iteration per cycle, busy high
//   S_DONE | one-cycle done pulse, new hi/lo visible
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] part, shreg, opnd;
    logic             is_div, dbz;
    logic             op_signed, op_long, op_mt, accept, last;
    logic [WIDTH-1:0] a_in, b_in;
    logic [WIDTH-1:0] part_nxt, sh_nxt, fin_hi, fin_lo;
    logic             q_bit;
`ifdef MULDIV_SIGNED_EN
    logic             neg_q, neg_r;
`endif

    always_comb begin
        op_signed = 1'b0;
        a_in      = a;
        b_in      = b;
`ifdef MULDIV_SIGNED_EN
        op_signed = (op == OP_MULT) || (op == OP_DIV);
        if (op_signed && a[WIDTH-1]) a_in = -a;
        if (op_signed && b[WIDTH-1]) b_in = -b;
`endif
        op_long = (op == OP_MULTU) || (op == OP_DIVU) || op_signed;
        op_mt   = (op == OP_MTHI) || (op == OP_MTLO);
        accept  = start && !abort && (state != S_RUN) && (op_long || op_mt);
        last    = cnt == CNT_W'(WIDTH - 1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN: begin
                if (abort)     state_nxt = S_IDLE;
                else if (last) state_nxt = S_DONE;
            end
            default: begin
                if (accept) state_nxt = op_long ? S_RUN : S_DONE;
                else        state_nxt = S_IDLE;
            end
        endcase
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .is_div   (is_div),
        .part     (part),
        .shift_in (is_div ? shreg[WIDTH-1] : shreg[0]),
        .opnd     (opnd),
        .part_nxt (part_nxt),
        .q_bit    (q_bit)
    );

    assign sh_nxt = is_div ? {shreg[WIDTH-2:0], q_bit} : {q_bit, shreg[WIDTH-1:1]};

    always_comb begin
        fin_hi = part_nxt;
        fin_lo = sh_nxt;
`ifdef MULDIV_SIGNED_EN
        if (!is_div && neg_q) begin
            {fin_hi, fin_lo} = -{part_nxt, sh_nxt};
        end else if (is_div) begin
            if (neg_q) fin_lo = -sh_nxt;
            if (neg_r) fin_hi = -part_nxt;
        end
`endif
        // zero divisor leaves the dividend in the remainder; quotient is forced to all ones
        if (dbz) fin_lo = '1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hi     <= '0;
            lo     <= '0;
            part   <= '0;
            shreg  <= '0;
            opnd   <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            dbz    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
`endif
        end else begin
            if (accept) begin
                if (op_long) begin
                    is_div <= op[0];
                    dbz    <= op[0] && (b == '0);
                    part   <= '0;
                    cnt    <= '0;
                    shreg  <= op[0] ? a_in : b_in;
                    opnd   <= op[0] ? b_in : a_in;
`ifdef MULDIV_SIGNED_EN
                    neg_q  <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_r  <= op_signed && op[0] && a[WIDTH-1];
`endif
                end else begin
                    dbz <= 1'b0;
                    if (op == OP_MTHI) hi <= a;
                    else               lo <= a;
                end
            end
            if (state == S_RUN && !abort) begin
                part  <= part_nxt;
                shreg <= sh_nxt;
                cnt   <= cnt + CNT_W'(1);
                if (last) begin
                    hi <= fin_hi;
                    lo <= fin_lo;
                end
            end
        end
    end

    assign busy        = state == S_RUN;
    assign done        = state == S_DONE;
    assign div_by_zero = (state == S_DONE) && dbz;

endmodule
